burst_ram_arbiter: RTL and testbench
====================================

// Module: burst_ram_arbiter
// PURPOSE
//  Shares one BurstRAM between two cache masters: port 0 = instruction cache, port 1 = data cache.
//  Each port presents the native br_ command/data interface, so a cache wires to it unchanged.
//  Every accepted command is captured into a per-port slot, scheduled round-robin and issued as one whole burst.
//  Read beats return only to the owning port.
// PARAMETERS
//  RAM_DEPTH_BITWIDTH       8   RAM address width (RAM words)
//  RAM_BURST_DATA_BITWIDTH  64  RAM data width; mask width = /8
//  RAM_BURST_DATA_COUNT     4   beats per burst (read or write)
// PORTS
//  clk             in   1    RAM clock; single clock domain
//  rst             in   1    reset, asynchronous, active-high
//  sN_cmd          in   1    port N command: 0 read, 1 write (N = 0,1; identical port set per N)
//  sN_cmd_en       in   1    port N command strobe, one cycle
//  sN_addr         in   RAM_DEPTH_BITWIDTH  port N burst start address
//  sN_wr_data      in   RAM_BURST_DATA_BITWIDTH  port N write beat
//  sN_data_mask    in   RAM_BURST_DATA_BITWIDTH/8  port N write byte mask
//  sN_rd_data      out  RAM_BURST_DATA_BITWIDTH  port N read beat (registered)
//  sN_rd_data_valid out 1    port N read beat valid
//  sN_busy         out  1    port N slot occupied; new commands ignored
//  br_cmd, br_cmd_en, br_addr, br_wr_data, br_data_mask  out  to BurstRAM (registered)
//  br_rd_data, br_rd_data_valid, br_busy                 in   from BurstRAM
// BEHAVIOUR
//  Reset: async; all outputs 0; slots empty; state IDLE; round-robin pointer = 1, so port 0 wins the first tie.
//  Accept: sN_cmd_en=1 with sN_busy=0 captures cmd/addr into slot N. sN_busy=1 from the next edge.
//   sN_cmd_en while sN_busy=1 is ignored: no capture, no error.
//  Write capture: beat 0 (wr_data, mask) is taken on the accept cycle.
//   Beats 1..COUNT-1 are taken unconditionally on the following COUNT-1 cycles.
//   A write slot is eligible only once all beats are captured.
//  FSM IDLE: when br_busy=0 and at least one eligible slot exists, pick a winner and go to ISSUE.
//   Winner: the only eligible slot, or on a tie the slot != last_grant. last_grant <= winner.
//   A slot that becomes eligible in the same cycle it would be picked is picked (no extra wait).
//  ISSUE (1 cycle): br_cmd_en=1, br_cmd, br_addr from the slot.
//   Write: br_wr_data/br_data_mask = beat 0, then go to WR.
//   Read: br_data_mask=0, then go to RD.
//  WR: br_cmd_en=0; drive beats 1..COUNT-1 on consecutive cycles.
//   After the last beat, the slot is freed and sN_busy=0 on the next edge; go to IDLE.
//  RD: br_cmd_en=0; count br_rd_data_valid beats.
//   Each beat is registered to the owner: sN_rd_data=br_rd_data, sN_rd_data_valid=1 one cycle later.
//   The other port's valid stays 0.
//   On beat COUNT, the slot is freed and sN_busy=0 with that last valid; go to IDLE.
//  br_rd_data_valid outside RD is ignored (e.g. stale beats after reset).
//  Latency: accept -> br_cmd_en >= 2 cycles; RAM beat -> port beat = 1 cycle.
//  Counters: beat counter is $clog2(COUNT) bits and wraps to 0 at burst end; RR pointer is 1 bit.
//  Fairness: a continuously re-requesting port is never granted twice while the other waits.
//  Reset mid-burst: burst is abandoned and both slots dropped; the requester must reissue.
// STRUCTURE
//  Shared package burst_ram_pkg: BR_CMD_READ/BR_CMD_WRITE, PORT_ICACHE=0/PORT_DCACHE=1, FSM encodings.
//  Sub-module burst_ram_arbiter_slot: one instance per port.
//   Holds the accept logic, cmd/addr registers, write beat buffer[COUNT], capture counter,
//   and the eligible/busy flags.
//  Top level: RR pointer, IDLE/ISSUE/WR/RD FSM, beat counter, read demux, br_ output registers.
// TESTING
//  1 Port 0 read @0x10, RAM returns A,B,C,D.
//    -> br_cmd_en 1 cycle, br_addr=0x10; s0 valid x4 = A..D; s1_rd_data_valid never 1.
//    -> s0_busy falls with last beat.
//  2 Both ports read in the same cycle (0x20 / 0x40) after reset.
//    -> port 0 issued first; port 1 issued after port 0's 4th beat; each gets its own data.
//  3 Port 1 write @0x08, beats 1,2,3,4, mask 0xFF then 0x0F.
//    -> br_wr_data 1,2,3,4 on 4 consecutive cycles from br_cmd_en; masks match; s1_busy clears after.
//  4 Both ports re-request immediately after every completion, 6 bursts.
//    -> grant order 0,1,0,1,0,1.
//  5 s0_cmd_en pulses again while s0_busy=1.
//    -> ignored; exactly one RAM burst for port 0.
//  6 rst pulsed during RD after 2 beats, stray valids follow.
//    -> outputs 0, no sN_rd_data_valid; a new port 1 read then completes normally.

Source files
------------

// File: rtl/burst_ram_pkg.sv
// Shared encodings for the BurstRAM arbiter: command codes, port ids, FSM states.
package burst_ram_pkg;

   localparam logic BR_CMD_READ  = 1'b0;
   localparam logic BR_CMD_WRITE = 1'b1;

   localparam logic PORT_ICACHE  = 1'b0;
   localparam logic PORT_DCACHE  = 1'b1;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_WR    = 2'd2,
      ST_RD    = 2'd3
   } arb_state_t;

endpackage

// File: rtl/burst_ram_arbiter_slot.sv
// One command slot: captures a cache command plus its write beats and holds it until the
// arbiter has finished the burst.
module burst_ram_arbiter_slot
   import burst_ram_pkg::*;
#(
   parameter int AW    = 8,
   parameter int DW    = 64,
   parameter int COUNT = 4,
   localparam int MW   = DW / 8,
   localparam int CW   = $clog2(COUNT)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          cmd_en,
   input  logic          cmd,
   input  logic [AW-1:0] addr,
   input  logic [DW-1:0] wr_data,
   input  logic [MW-1:0] data_mask,
   input  logic          done,
   input  logic [CW-1:0] beat_sel,
   output logic          busy,
   output logic          eligible,
   output logic          slot_cmd,
   output logic [AW-1:0] slot_addr,
   output logic [DW-1:0] beat_data,
   output logic [MW-1:0] beat_mask
);

   logic [DW-1:0] data_buf [COUNT];
   logic [MW-1:0] mask_buf [COUNT];
   logic [CW-1:0] cap_cnt;
   logic          capturing;

   // Accept a command when free, then take the remaining write beats back to back.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         busy      <= 1'b0;
         capturing <= 1'b0;
         cap_cnt   <= '0;
         slot_cmd  <= BR_CMD_READ;
         slot_addr <= '0;
         for (int i = 0; i < COUNT; i++) begin
            data_buf[i] <= '0;
            mask_buf[i] <= '0;
         end
      end else begin
         if (cmd_en && !busy) begin
            busy        <= 1'b1;
            slot_cmd    <= cmd;
            slot_addr   <= addr;
            data_buf[0] <= wr_data;
            mask_buf[0] <= data_mask;
            capturing   <= (cmd == BR_CMD_WRITE);
            cap_cnt     <= CW'(1);
         end else if (capturing) begin
            data_buf[cap_cnt] <= wr_data;
            mask_buf[cap_cnt] <= data_mask;
            cap_cnt           <= cap_cnt + CW'(1);
            if (cap_cnt == CW'(COUNT - 1))
               capturing <= 1'b0;
         end
         if (done)
            busy <= 1'b0;
      end
   end

   // A write may only be issued once every beat is buffered.
   assign eligible  = busy && !capturing;
   assign beat_data = data_buf[beat_sel];
   assign beat_mask = mask_buf[beat_sel];

endmodule

// File: rtl/burst_ram_arbiter.sv
// Two-port round-robin arbiter sharing one BurstRAM between instruction and data caches.
//
// state    | meaning
// ST_IDLE  | waiting for an eligible slot and br_busy=0
// ST_ISSUE | br_cmd_en high for one cycle, beat 0 on the bus
// ST_WR    | streaming write beats 1..COUNT-1, then free the slot
// ST_RD    | forwarding COUNT read beats to the owning port
module burst_ram_arbiter
   import burst_ram_pkg::*;
#(
   parameter int RAM_DEPTH_BITWIDTH      = 8,
   parameter int RAM_BURST_DATA_BITWIDTH = 64,
   parameter int RAM_BURST_DATA_COUNT    = 4,
   localparam int AW = RAM_DEPTH_BITWIDTH,
   localparam int DW = RAM_BURST_DATA_BITWIDTH,
   localparam int MW = DW / 8,
   localparam int CW = $clog2(RAM_BURST_DATA_COUNT)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          s0_cmd,
   input  logic          s0_cmd_en,
   input  logic [AW-1:0] s0_addr,
   input  logic [DW-1:0] s0_wr_data,
   input  logic [MW-1:0] s0_data_mask,
   output logic [DW-1:0] s0_rd_data,
   output logic          s0_rd_data_valid,
   output logic          s0_busy,
   input  logic          s1_cmd,
   input  logic          s1_cmd_en,
   input  logic [AW-1:0] s1_addr,
   input  logic [DW-1:0] s1_wr_data,
   input  logic [MW-1:0] s1_data_mask,
   output logic [DW-1:0] s1_rd_data,
   output logic          s1_rd_data_valid,
   output logic          s1_busy,
   output logic          br_cmd,
   output logic          br_cmd_en,
   output logic [AW-1:0] br_addr,
   output logic [DW-1:0] br_wr_data,
   output logic [MW-1:0] br_data_mask,
   input  logic [DW-1:0] br_rd_data,
   input  logic          br_rd_data_valid,
   input  logic          br_busy
);

   logic [1:0]    eligible, done;
   logic          slot_cmd  [2];
   logic [AW-1:0] slot_addr [2];
   logic [DW-1:0] beat_data [2];
   logic [MW-1:0] beat_mask [2];

   arb_state_t    state, state_d;
   logic          grant, grant_d, last_grant, last_grant_d, winner;
   logic [CW-1:0] beat_cnt, beat_cnt_d;
   logic          br_cmd_d, br_cmd_en_d;
   logic [AW-1:0] br_addr_d;
   logic [DW-1:0] br_wr_data_d, s0_rd_data_d, s1_rd_data_d;
   logic [MW-1:0] br_data_mask_d;
   logic [1:0]    rd_valid_d;

   burst_ram_arbiter_slot #(.AW(AW), .DW(DW), .COUNT(RAM_BURST_DATA_COUNT)) u_slot0 (
      .clk(clk), .rst(rst), .cmd_en(s0_cmd_en), .cmd(s0_cmd), .addr(s0_addr),
      .wr_data(s0_wr_data), .data_mask(s0_data_mask), .done(done[PORT_ICACHE]),
      .beat_sel(beat_cnt), .busy(s0_busy), .eligible(eligible[PORT_ICACHE]),
      .slot_cmd(slot_cmd[PORT_ICACHE]), .slot_addr(slot_addr[PORT_ICACHE]),
      .beat_data(beat_data[PORT_ICACHE]), .beat_mask(beat_mask[PORT_ICACHE])
   );

   burst_ram_arbiter_slot #(.AW(AW), .DW(DW), .COUNT(RAM_BURST_DATA_COUNT)) u_slot1 (
      .clk(clk), .rst(rst), .cmd_en(s1_cmd_en), .cmd(s1_cmd), .addr(s1_addr),
      .wr_data(s1_wr_data), .data_mask(s1_data_mask), .done(done[PORT_DCACHE]),
      .beat_sel(beat_cnt), .busy(s1_busy), .eligible(eligible[PORT_DCACHE]),
      .slot_cmd(slot_cmd[PORT_DCACHE]), .slot_addr(slot_addr[PORT_DCACHE]),
      .beat_data(beat_data[PORT_DCACHE]), .beat_mask(beat_mask[PORT_DCACHE])
   );

   // Next state, next register outputs and slot release; beat_cnt is 0 whenever in IDLE.
   always_comb begin
      state_d        = state;
      grant_d        = grant;
      last_grant_d   = last_grant;
      beat_cnt_d     = beat_cnt;
      br_cmd_en_d    = 1'b0;
      br_cmd_d       = br_cmd;
      br_addr_d      = br_addr;
      br_wr_data_d   = '0;
      br_data_mask_d = '0;
      rd_valid_d     = '0;
      s0_rd_data_d   = s0_rd_data;
      s1_rd_data_d   = s1_rd_data;
      done           = '0;
      winner         = (&eligible) ? ~last_grant : eligible[PORT_DCACHE];
      case (state)
         ST_IDLE: begin
            if (!br_busy && |eligible) begin
               state_d      = ST_ISSUE;
               grant_d      = winner;
               last_grant_d = winner;
               br_cmd_en_d  = 1'b1;
               br_cmd_d     = slot_cmd[winner];
               br_addr_d    = slot_addr[winner];
               if (slot_cmd[winner] == BR_CMD_WRITE) begin
                  br_wr_data_d   = beat_data[winner];
                  br_data_mask_d = beat_mask[winner];
                  beat_cnt_d     = CW'(1);
               end
            end
         end
         ST_ISSUE: begin
            if (br_cmd == BR_CMD_WRITE) begin
               br_wr_data_d   = beat_data[grant];
               br_data_mask_d = beat_mask[grant];
               beat_cnt_d     = beat_cnt + CW'(1);
               state_d        = ST_WR;
            end else begin
               state_d = ST_RD;
            end
         end
         ST_WR: begin
            if (beat_cnt == '0) begin
               done[grant] = 1'b1;
               state_d     = ST_IDLE;
            end else begin
               br_wr_data_d   = beat_data[grant];
               br_data_mask_d = beat_mask[grant];
               beat_cnt_d     = beat_cnt + CW'(1);
            end
         end
         ST_RD: begin
            if (br_rd_data_valid) begin
               rd_valid_d[grant] = 1'b1;
               if (grant == PORT_ICACHE) s0_rd_data_d = br_rd_data;
               else                      s1_rd_data_d = br_rd_data;
               beat_cnt_d = beat_cnt + CW'(1);
               if (beat_cnt == CW'(RAM_BURST_DATA_COUNT - 1)) begin
                  done[grant] = 1'b1;
                  state_d     = ST_IDLE;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // State, arbitration and all externally visible registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state            <= ST_IDLE;
         grant            <= PORT_ICACHE;
         last_grant       <= PORT_DCACHE;
         beat_cnt         <= '0;
         br_cmd           <= BR_CMD_READ;
         br_cmd_en        <= 1'b0;
         br_addr          <= '0;
         br_wr_data       <= '0;
         br_data_mask     <= '0;
         s0_rd_data       <= '0;
         s1_rd_data       <= '0;
         s0_rd_data_valid <= 1'b0;
         s1_rd_data_valid <= 1'b0;
      end else begin
         state            <= state_d;
         grant            <= grant_d;
         last_grant       <= last_grant_d;
         beat_cnt         <= beat_cnt_d;
         br_cmd           <= br_cmd_d;
         br_cmd_en        <= br_cmd_en_d;
         br_addr          <= br_addr_d;
         br_wr_data       <= br_wr_data_d;
         br_data_mask     <= br_data_mask_d;
         s0_rd_data       <= s0_rd_data_d;
         s1_rd_data       <= s1_rd_data_d;
         s0_rd_data_valid <= rd_valid_d[PORT_ICACHE];
         s1_rd_data_valid <= rd_valid_d[PORT_DCACHE];
      end
   end

endmodule

// File: tb/tb_burst_ram_arbiter.sv
// Directed bench for burst_ram_arbiter: reads, tie-break, write streaming, fairness,
// ignored re-strobes and reset mid-burst.
module tb_burst_ram_arbiter;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        s0_cmd = 1'b0, s0_cmd_en = 1'b0;
   logic [7:0]  s0_addr = '0;
   logic [63:0] s0_wr_data = '0;
   logic [7:0]  s0_data_mask = '0;
   logic [63:0] s0_rd_data;
   logic        s0_rd_data_valid, s0_busy;
   logic        s1_cmd = 1'b0, s1_cmd_en = 1'b0;
   logic [7:0]  s1_addr = '0;
   logic [63:0] s1_wr_data = '0;
   logic [7:0]  s1_data_mask = '0;
   logic [63:0] s1_rd_data;
   logic        s1_rd_data_valid, s1_busy;
   logic        br_cmd, br_cmd_en;
   logic [7:0]  br_addr;
   logic [63:0] br_wr_data;
   logic [7:0]  br_data_mask;
   logic [63:0] br_rd_data = '0;
   logic        br_rd_data_valid = 1'b0;
   logic        br_busy = 1'b0;

   int n_pass  = 0;
   int n_total = 0;
   int n_cmd;

   burst_ram_arbiter dut (
      .clk(clk), .rst(rst),
      .s0_cmd(s0_cmd), .s0_cmd_en(s0_cmd_en), .s0_addr(s0_addr), .s0_wr_data(s0_wr_data),
      .s0_data_mask(s0_data_mask), .s0_rd_data(s0_rd_data), .s0_rd_data_valid(s0_rd_data_valid),
      .s0_busy(s0_busy),
      .s1_cmd(s1_cmd), .s1_cmd_en(s1_cmd_en), .s1_addr(s1_addr), .s1_wr_data(s1_wr_data),
      .s1_data_mask(s1_data_mask), .s1_rd_data(s1_rd_data), .s1_rd_data_valid(s1_rd_data_valid),
      .s1_busy(s1_busy),
      .br_cmd(br_cmd), .br_cmd_en(br_cmd_en), .br_addr(br_addr), .br_wr_data(br_wr_data),
      .br_data_mask(br_data_mask), .br_rd_data(br_rd_data), .br_rd_data_valid(br_rd_data_valid),
      .br_busy(br_busy)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      s0_cmd_en = 1'b0; s1_cmd_en = 1'b0;
      br_rd_data_valid = 1'b0; br_rd_data = '0;
      tick();
      tick();
      rst = 1'b0;
      tick();
   endtask

   task automatic wait_cmd(input string tag);
      for (int i = 0; i < 20 && br_cmd_en !== 1'b1; i++) tick();
      check(tag, br_cmd_en, 1);
   endtask

   // Return four read beats base..base+3 and check they reach only the owning port.
   task automatic rd_beats(input logic port, input logic [63:0] base);
      for (int k = 0; k < 4; k++) begin
         br_rd_data       = base + 64'(k);
         br_rd_data_valid = 1'b1;
         tick();
         if (port == 1'b0) begin
            check("s0_rd_valid", s0_rd_data_valid, 1);
            check("s0_rd_data", s0_rd_data, base + 64'(k));
            check("s1_rd_quiet", s1_rd_data_valid, 0);
            check("s0_busy_during_rd", s0_busy, (k < 3) ? 1 : 0);
         end else begin
            check("s1_rd_valid", s1_rd_data_valid, 1);
            check("s1_rd_data", s1_rd_data, base + 64'(k));
            check("s0_rd_quiet", s0_rd_data_valid, 0);
            check("s1_busy_during_rd", s1_busy, (k < 3) ? 1 : 0);
         end
      end
      br_rd_data_valid = 1'b0;
      br_rd_data       = '0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      // Reset state
      do_reset();
      check("rst_br_cmd_en", br_cmd_en, 0);
      check("rst_s0_busy", s0_busy, 0);
      check("rst_s1_busy", s1_busy, 0);
      check("rst_s0_valid", s0_rd_data_valid, 0);
      check("rst_br_addr", br_addr, 0);

      // 1: port 0 read @0x10
      s0_cmd = 1'b0; s0_addr = 8'h10; s0_cmd_en = 1'b1;
      tick();
      s0_cmd_en = 1'b0;
      check("t1_s0_busy", s0_busy, 1);
      check("t1_no_cmd_yet", br_cmd_en, 0);
      tick();
      check("t1_cmd_en", br_cmd_en, 1);
      check("t1_addr", br_addr, 8'h10);
      check("t1_cmd", br_cmd, 0);
      check("t1_mask", br_data_mask, 0);
      tick();
      check("t1_cmd_en_one_cycle", br_cmd_en, 0);
      rd_beats(1'b0, 64'hA0);
      tick();
      check("t1_valid_drops", s0_rd_data_valid, 0);

      // 2: simultaneous reads after reset, port 0 wins
      do_reset();
      s0_cmd = 1'b0; s0_addr = 8'h20; s0_cmd_en = 1'b1;
      s1_cmd = 1'b0; s1_addr = 8'h40; s1_cmd_en = 1'b1;
      tick();
      s0_cmd_en = 1'b0; s1_cmd_en = 1'b0;
      wait_cmd("t2_first_cmd");
      check("t2_first_addr", br_addr, 8'h20);
      tick();
      rd_beats(1'b0, 64'h200);
      check("t2_gap", br_cmd_en, 0);
      check("t2_s1_still_busy", s1_busy, 1);
      tick();
      check("t2_second_cmd", br_cmd_en, 1);
      check("t2_second_addr", br_addr, 8'h40);
      tick();
      rd_beats(1'b1, 64'h400);

      // 3: port 1 write @0x08
      s1_cmd = 1'b1; s1_addr = 8'h08; s1_wr_data = 64'd1; s1_data_mask = 8'hFF; s1_cmd_en = 1'b1;
      tick();
      s1_cmd_en = 1'b0;
      s1_wr_data = 64'd2; s1_data_mask = 8'h0F;
      tick();
      s1_wr_data = 64'd3;
      tick();
      s1_wr_data = 64'd4;
      tick();
      s1_wr_data = 64'd0; s1_data_mask = 8'h00;
      check("t3_not_before_capture", br_cmd_en, 0);
      tick();
      check("t3_cmd_en", br_cmd_en, 1);
      check("t3_cmd", br_cmd, 1);
      check("t3_addr", br_addr, 8'h08);
      check("t3_beat0", br_wr_data, 64'd1);
      check("t3_mask0", br_data_mask, 8'hFF);
      for (int b = 2; b <= 4; b++) begin
         tick();
         check("t3_cmd_en_low", br_cmd_en, 0);
         check("t3_beat", br_wr_data, 64'(b));
         check("t3_mask", br_data_mask, 8'h0F);
         check("t3_s1_busy_in_burst", s1_busy, 1);
      end
      tick();
      check("t3_s1_freed", s1_busy, 0);

      // 4: both ports re-request after every completion
      do_reset();
      s0_cmd = 1'b0; s0_addr = 8'h30; s0_cmd_en = 1'b1;
      s1_cmd = 1'b0; s1_addr = 8'h50; s1_cmd_en = 1'b1;
      tick();
      s0_cmd_en = 1'b0; s1_cmd_en = 1'b0;
      for (int n = 0; n < 6; n++) begin
         wait_cmd("t4_cmd");
         check("t4_grant_order", br_addr, (n % 2 == 0) ? 8'h30 : 8'h50);
         tick();
         rd_beats(1'(n % 2), 64'h1000 * 64'(n + 1));
         if (n % 2 == 0) s0_cmd_en = 1'b1;
         else            s1_cmd_en = 1'b1;
         tick();
         s0_cmd_en = 1'b0; s1_cmd_en = 1'b0;
      end

      // 5: re-strobe while busy is ignored
      do_reset();
      s0_cmd = 1'b0; s0_addr = 8'h60; s0_cmd_en = 1'b1;
      tick();
      s0_addr = 8'h70;
      tick();
      s0_cmd_en = 1'b0;
      wait_cmd("t5_cmd");
      check("t5_addr", br_addr, 8'h60);
      tick();
      rd_beats(1'b0, 64'h600);
      n_cmd = 0;
      for (int i = 0; i < 8; i++) begin
         tick();
         if (br_cmd_en === 1'b1) n_cmd++;
      end
      check("t5_extra_bursts", 64'(n_cmd), 0);
      check("t5_s0_idle", s0_busy, 0);

      // 6: reset during a read burst
      do_reset();
      s0_cmd = 1'b0; s0_addr = 8'h11; s0_cmd_en = 1'b1;
      tick();
      s0_cmd_en = 1'b0;
      wait_cmd("t6_cmd");
      tick();
      for (int k = 0; k < 2; k++) begin
         br_rd_data = 64'h700 + 64'(k); br_rd_data_valid = 1'b1;
         tick();
         check("t6_pre_rst_valid", s0_rd_data_valid, 1);
      end
      rst = 1'b1;
      #1;
      check("t6_rst_s0_busy", s0_busy, 0);
      check("t6_rst_s0_valid", s0_rd_data_valid, 0);
      check("t6_rst_s0_data", s0_rd_data, 0);
      check("t6_rst_br_addr", br_addr, 0);
      tick();
      rst = 1'b0;
      for (int i = 0; i < 2; i++) begin
         tick();
         check("t6_stray_s0", s0_rd_data_valid, 0);
         check("t6_stray_s1", s1_rd_data_valid, 0);
         check("t6_stray_cmd", br_cmd_en, 0);
      end
      br_rd_data_valid = 1'b0;
      s1_cmd = 1'b0; s1_addr = 8'h22; s1_cmd_en = 1'b1;
      tick();
      s1_cmd_en = 1'b0;
      wait_cmd("t6_new_cmd");
      check("t6_new_addr", br_addr, 8'h22);
      tick();
      rd_beats(1'b1, 64'h900);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
